// File: rtl/div_pkg.sv
// Shared types and elaboration helpers for the sequential divider.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH_MIN = 4;
    localparam int DIV_WIDTH_MAX = 64;

    // Counter must hold 0..WIDTH: slot 0 is the magnitude-load cycle, 1..WIDTH are iterations.
    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic bit div_width_ok(input int width);
        return (width >= DIV_WIDTH_MIN) && (width <= DIV_WIDTH_MAX) && ((width % 2) == 0);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 non-restoring division step on a WIDTH+1-bit signed partial remainder.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvs_ext;
    logic [WIDTH+1:0] sum;

    // Shift is done one bit wider so 2*P+bit never overflows before the add/sub.
    always_comb begin
        shifted = {rem_in, bit_in};
        dvs_ext = {2'b00, divisor};
        sum     = rem_in[WIDTH] ? (shifted + dvs_ext) : (shifted - dvs_ext);
        rem_out = sum[WIDTH:0];
        q_bit   = ~sum[WIDTH+1];
    end

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned divider, one quotient bit per cycle.
// Optional DIV_ZERO_FLAG_EN: short-circuits zero divisors and adds the div_zero output.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_q,
    output logic [WIDTH-1:0] data_r,
    output logic             busy
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    if (!div_width_ok(WIDTH)) begin : g_bad_width
        $error("div_seq: WIDTH must be even and within 4..64");
    end

    localparam int             CW   = div_cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             a_neg;
        logic             b_neg;
    } op_t;

    div_state_e       state;
    logic [CW-1:0]    cnt;
    op_t              op;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_sh;

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH:0]   step_rem;
    logic             step_q;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Negating MIN wraps back to MIN, which is still the correct unsigned magnitude.
    always_comb begin
        a_mag_c = op.a_neg ? -op.a : op.a;
        b_mag_c = op.b_neg ? -op.b : op.b;
        rem_fix = prem[WIDTH] ? (prem[WIDTH-1:0] + b_mag) : prem[WIDTH-1:0];
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem),
        .bit_in  (a_sh[WIDTH-1]),
        .divisor (b_mag),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op     <= '0;
            prem   <= '0;
            a_sh   <= '0;
            b_mag  <= '0;
            q_sh   <= '0;
            data_q <= '0;
            data_r <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op.a     <= data_a;
                        op.b     <= data_b;
                        op.a_neg <= sign & data_a[WIDTH-1];
                        op.b_neg <= sign & data_b[WIDTH-1];
                        cnt      <= '0;
`ifdef DIV_ZERO_FLAG_EN
                        if (data_b == '0) begin
                            state    <= ST_DONE;
                            data_q   <= '1;
                            data_r   <= data_a;
                            div_zero <= 1'b1;
                        end else begin
                            state    <= ST_CALC;
                            div_zero <= 1'b0;
                        end
`else
                        state <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    if (cnt == '0) begin
                        a_sh  <= a_mag_c;
                        b_mag <= b_mag_c;
                        prem  <= '0;
                        q_sh  <= '0;
                        cnt   <= CW'(1);
                    end else begin
                        prem <= step_rem;
                        a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                        q_sh <= {q_sh[WIDTH-2:0], step_q};
                        if (cnt == LAST) begin
                            state <= ST_FIX;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_FIX: begin
                    data_q <= (op.a_neg ^ op.b_neg) ? -q_sh : q_sh;
                    data_r <= op.a_neg ? -rem_fix : rem_fix;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 4..64, even).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand transfer request.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 data_a  input  WIDTH  dividend.
REQ-007 data_b  input  WIDTH  divisor.
REQ-008 sign  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 data_q  output  WIDTH  quotient.
REQ-012 data_r  output  WIDTH  remainder.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 div_zero  output  1  divisor was zero (present only with DIV_ZERO_FLAG_EN).

Function
REQ-015 States IDLE, CALC, FIX, DONE; IDLE->CALC on in_valid&in_ready; CALC->FIX after WIDTH iterations; FIX->DONE after one cycle; DONE->IDLE on out_ready.
REQ-016 in_ready SHALL equal (state==IDLE); operands, sign and operand signs latched on the accept edge; inputs ignored afterwards.
REQ-017 CALC SHALL perform one radix-2 non-restoring step per cycle on magnitudes (|a|, |b| when sign=1 and MSB set), WIDTH+1-bit partial remainder, iteration counter of clog2(WIDTH+1) bits.
REQ-018 FIX SHALL add divisor back if partial remainder negative, then negate quotient if sign & (a_msb ^ b_msb), negate remainder if sign & a_msb.
REQ-019 Remainder sign SHALL follow the dividend only in signed mode; unsigned results never negated.
REQ-020 Signed MIN / -1 SHALL yield q=MIN, r=0 (wrap, no flag).
REQ-021 Latency: out_valid rises exactly WIDTH+2 cycles after the accept edge.
REQ-022 In DONE, out_valid=1 and data_q/data_r/div_zero SHALL stay constant until the out_ready edge; out_ready outside DONE ignored.
REQ-023 New operands accepted no earlier than the cycle after DONE->IDLE (no back-to-back overlap).
REQ-024 data_q/data_r SHALL be registered outputs, unchanged except in FIX.

Reset
REQ-025 rst high at any clock edge, including mid-CALC/FIX/DONE, SHALL force IDLE, in_ready=1, out_valid=0, busy=0, data_q=0, data_r=0, div_zero=0, counter=0; in-flight operation discarded.
REQ-026 rst takes priority over in_valid and out_ready in the same cycle.

Configuration
REQ-027 Macro DIV_ZERO_FLAG_EN defined: divisor==0 detected at accept, block goes IDLE->DONE directly next cycle with q=all-ones, r=data_a (unmodified), div_zero=1.
REQ-028 Macro undefined: no div_zero port, zero divisor runs full WIDTH+2 latency; result SHALL be q=all-ones magnitude sign-fixed per REQ-018, r per REQ-018, with no further guarantee.

Structure
REQ-029 Package div_pkg SHALL hold the state enum type, the counter-width function and the parameter-range checks.
REQ-030 Combinational sub-module div_step SHALL implement one non-restoring step (inputs: partial remainder, next dividend bit, divisor; outputs: new remainder, quotient bit); div_seq instantiates it once.

Verification (WIDTH=32)
REQ-031 Unsigned 100/7 -> q=14, r=2, out_valid 34 cycles after accept.
REQ-032 Signed 0xFFFFFFF9 / 2 (-7/2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; same operands unsigned -> q=0x7FFFFFFC, r=1.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
REQ-034 With DIV_ZERO_FLAG_EN, 5/0 -> out_valid next cycle, q=0xFFFFFFFF, r=5, div_zero=1.
REQ-035 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; result consumed on first out_ready edge, in_ready=1 next cycle.
REQ-036 rst asserted at CALC iteration 10 -> next cycle IDLE, all outputs 0, in_ready=1; following 9/3 returns q=3, r=0.
